// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and receiver: FSM state encodings and frame length.
// Parity support is selected at build time with the UART_TX_PARITY_EN macro.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
   localparam int unsigned FRAME_OVERHEAD_BITS = 3;
`else
   localparam int unsigned FRAME_OVERHEAD_BITS = 2;
`endif

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } uart_state_e;

   // Line bits per character: start + data + optional parity + stop.
   function automatic int unsigned frame_bits(input int unsigned data_width);
      return data_width + FRAME_OVERHEAD_BITS;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO. Pointers carry an extra MSB so that full and empty can be told apart;
// o_wr_ready depends only on registered pointers, never on i_wr_valid.
module uart_tx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_wr_valid,
   output logic                  o_wr_ready,
   input  logic                  i_rd_en,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic                  o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]           r_wr_ptr;
   logic [AW:0]           r_rd_ptr;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;

   assign w_empty    = (r_wr_ptr == r_rd_ptr);
   assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   // A pop in the same cycle does not free a slot for a push into a full FIFO.
   assign w_push     = i_wr_valid && !w_full;
   assign w_pop      = i_rd_en && !w_empty;
   assign o_wr_ready = !w_full;
   assign o_empty    = w_empty;
   assign o_rd_data  = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO feeding a start/data/[parity]/stop serialiser, LSB first.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int BAUD_DIV   = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_valid,
   output logic                  o_ready,
   output logic                  o_tx,
   output logic                  o_busy
);

   localparam int BW = $clog2(BAUD_DIV);
   localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   uart_state_e           r_state;
   uart_state_e           w_state_next;
   logic [BW-1:0]         r_baud;
   logic [IW-1:0]         r_bit_idx;
   logic [IW-1:0]         w_bit_idx_next;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_tx;
   logic                  w_tx_next;
   logic                  w_pop;
   logic                  w_baud_done;
   logic                  w_last_bit;
   logic [DATA_WIDTH-1:0] w_fifo_data;
   logic                  w_fifo_empty;

   uart_tx_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_wr_data  (i_data),
      .i_wr_valid (i_valid),
      .o_wr_ready (o_ready),
      .i_rd_en    (w_pop),
      .o_rd_data  (w_fifo_data),
      .o_empty    (w_fifo_empty)
   );

   assign w_baud_done = (r_baud == BW'(BAUD_DIV - 1));
   assign w_last_bit  = (r_bit_idx == IW'(DATA_WIDTH - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:   if (!w_fifo_empty) w_state_next = ST_START;
         ST_START:  if (w_baud_done) w_state_next = ST_DATA;
`ifdef UART_TX_PARITY_EN
         ST_DATA:   if (w_baud_done && w_last_bit) w_state_next = ST_PARITY;
         ST_PARITY: if (w_baud_done) w_state_next = ST_STOP;
`else
         ST_DATA:   if (w_baud_done && w_last_bit) w_state_next = ST_STOP;
`endif
         // Back-to-back characters go straight from stop to the next start bit.
         ST_STOP:   if (w_baud_done) w_state_next = w_fifo_empty ? ST_IDLE : ST_START;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_pop          = ((r_state == ST_IDLE) && !w_fifo_empty) ||
                       ((r_state == ST_STOP) && w_baud_done && !w_fifo_empty);
      w_bit_idx_next = r_bit_idx;
      if ((r_state == ST_DATA) && w_baud_done)
         w_bit_idx_next = w_last_bit ? '0 : r_bit_idx + IW'(1);
      // o_tx is registered, so it is loaded with the level of the state being entered.
      w_tx_next = 1'b1;
      case (w_state_next)
         ST_START:  w_tx_next = 1'b0;
         ST_DATA:   w_tx_next = r_data[w_bit_idx_next];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: w_tx_next = ^r_data;
`endif
         default:   w_tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_data    <= '0;
         r_tx      <= 1'b1;
      end else begin
         // Every line bit ends on w_baud_done, so restarting there covers each state entry.
         if ((r_state == ST_IDLE) || w_baud_done) r_baud <= '0;
         else                                    r_baud <= r_baud + BW'(1);
         r_bit_idx <= w_bit_idx_next;
         if (w_pop) r_data <= w_fifo_data;
         r_tx <= w_tx_next;
      end
   end

   assign o_tx   = r_tx;
   assign o_busy = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: directed scenarios plus random traffic,
// with a line monitor decoding frames against an expected-byte queue.
module tb_uart_tx_buffered;

   localparam int DW = 8;
   localparam int BD = 16;
   localparam int FD = 4;
`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FRAME_BITS = 1 + DW + PAR + 1;
   localparam int FRAME_CYC  = FRAME_BITS * BD;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] i_data;
   logic          i_valid;
   logic          o_ready;
   logic          o_tx;
   logic          o_busy;

   int            checks_total  = 0;
   int            checks_passed = 0;
   int            cyc           = 0;
   int            last_acc_cyc  = 0;
   int            frames_done   = 0;

   logic [DW-1:0] exp_q[$];
   int            start_cyc[$];

   bit            mon_active = 0;
   bit            mon_bad    = 0;
   int            mon_cnt    = 0;
   int            mon_idx    = 0;
   logic [DW-1:0] mon_exp    = '0;
   logic [DW-1:0] mon_rx     = '0;

   uart_tx_buffered #(
      .DATA_WIDTH (DW),
      .BAUD_DIV   (BD),
      .FIFO_DEPTH (FD)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_data  (i_data),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .o_tx    (o_tx),
      .o_busy  (o_busy)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, got %0d cycles required fewer", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks_total++;
      if (act === exp) checks_passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Reference model of one frame: start 0, data LSB first, optional even parity, stop 1.
   function automatic logic exp_bit(input logic [DW-1:0] d, input int i);
      if (i == 0) return 1'b0;
      if (i <= DW) return d[i-1];
      if ((PAR != 0) && (i == DW + 1)) return ^d;
      return 1'b1;
   endfunction

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [DW-1:0] d, input bit hold, output bit acc);
      int k;
      bit rdy;
      k = 0;
      acc = 0;
      i_valid = 1'b1;
      i_data  = d;
      while (1) begin
         rdy = o_ready;
         @(posedge clk);
         #1;
         k++;
         if (rdy) begin
            acc = 1;
            exp_q.push_back(d);
            last_acc_cyc = cyc;
            break;
         end
         if (!hold) break;
         if (k >= 5000) begin
            check("push_timeout", 0, 1);
            break;
         end
      end
      i_valid = 1'b0;
   endtask

   task automatic wait_frames(input int n, input int budget);
      int k;
      k = 0;
      while ((frames_done < n) && (k < budget)) begin
         @(negedge clk);
         #1;
         k++;
      end
      if (frames_done < n) check("wait_frames_timeout", frames_done, n);
   endtask

   // monitor / scoreboard: decodes the line every cycle against the expected queue
   always @(negedge clk) begin
      if (!rst_n) begin
         mon_active = 0;
      end else if (!mon_active) begin
         if (o_tx === 1'b0) begin
            start_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               check("unexpected_frame", 1, 0);
               mon_exp = '0;
            end else begin
               mon_exp = exp_q.pop_front();
            end
            mon_active = 1;
            mon_cnt    = 1;
            mon_bad    = 0;
            mon_rx     = '0;
         end
      end else begin
         mon_idx = mon_cnt / BD;
         if (o_tx !== exp_bit(mon_exp, mon_idx)) mon_bad = 1;
         if (((mon_cnt % BD) == BD / 2) && (mon_idx >= 1) && (mon_idx <= DW))
            mon_rx[mon_idx-1] = o_tx;
         mon_cnt++;
         if (mon_cnt == FRAME_CYC) begin
            check("frame_data", 32'(mon_rx), 32'(mon_exp));
            check("frame_bits_bad", 32'(mon_bad), 0);
            frames_done++;
            mon_active = 0;
         end
      end
   end

   initial begin
      bit acc;
      bit [5:0] acc_mask;
      int base;
      int f0;
      int k;
      int s;
      logic [DW-1:0] ovf_bytes [6];

      rst_n   = 1'b0;
      i_valid = 1'b0;
      i_data  = '0;

      // reset idle
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step();
      check("reset_tx", 32'(o_tx), 1);
      check("reset_ready", 32'(o_ready), 1);
      check("reset_busy", 32'(o_busy), 0);

      // single character 0xA5
      base = start_cyc.size();
      f0 = frames_done;
      push_byte(8'hA5, 1, acc);
      wait_frames(f0 + 1, FRAME_CYC + 50);
      if (start_cyc.size() > base) check("start_latency", start_cyc[base], last_acc_cyc + 1);
      else check("start_seen", 0, 1);
      check("busy_last_stop", 32'(o_busy), 1);
      @(negedge clk);
      #1;
      check("busy_fall_single", 32'(o_busy), 0);
      check("idle_tx_single", 32'(o_tx), 1);

      // back-to-back 0x00, 0xFF, 0x55
      step();
      base = start_cyc.size();
      f0 = frames_done;
      push_byte(8'h00, 1, acc);
      push_byte(8'hFF, 1, acc);
      push_byte(8'h55, 1, acc);
      wait_frames(f0 + 3, 3 * FRAME_CYC + 50);
      if (start_cyc.size() >= base + 3) begin
         check("b2b_gap_1", start_cyc[base+1] - start_cyc[base], FRAME_CYC);
         check("b2b_gap_2", start_cyc[base+2] - start_cyc[base+1], FRAME_CYC);
      end else begin
         check("b2b_frames_seen", start_cyc.size() - base, 3);
      end
      check("busy_b2b_last_stop", 32'(o_busy), 1);
      @(negedge clk);
      #1;
      check("busy_fall_b2b", 32'(o_busy), 0);

      // overflow: 0x01..0x06 on consecutive cycles, 0x06 must be dropped
      step();
      f0 = frames_done;
      acc_mask = '0;
      for (int i = 0; i < 6; i++) ovf_bytes[i] = DW'(i + 1);
      for (int i = 0; i < 6; i++) begin
         push_byte(ovf_bytes[i], 0, acc);
         acc_mask[i] = acc;
         if (i == 4) check("ready_low_when_full", 32'(o_ready), 0);
      end
      check("overflow_accept_mask", 32'(acc_mask), 32'h1F);
      wait_frames(f0 + 5, 6 * FRAME_CYC);
      repeat (FRAME_CYC + 20) @(negedge clk);
      check("overflow_frame_count", frames_done - f0, 5);
      check("overflow_queue_empty", exp_q.size(), 0);

`ifdef UART_TX_PARITY_EN
      // parity: 0x07 -> 1, 0x03 -> 0, checked bit by bit by the monitor
      step();
      f0 = frames_done;
      push_byte(8'h07, 1, acc);
      push_byte(8'h03, 1, acc);
      wait_frames(f0 + 2, 3 * FRAME_CYC);
`endif

      // reset in data bit 3 of 0x3C with two bytes queued
      step();
      base = start_cyc.size();
      push_byte(8'h3C, 1, acc);
      push_byte(8'hAA, 1, acc);
      push_byte(8'h55, 1, acc);
      k = 0;
      while ((start_cyc.size() <= base) && (k < 100)) begin
         @(negedge clk);
         k++;
      end
      if (start_cyc.size() > base) begin
         s = start_cyc[base];
         k = 0;
         while ((cyc < s + 4 * BD + BD / 2) && (k < FRAME_CYC)) begin
            @(negedge clk);
            k++;
         end
         check("tx_before_reset_bit3", 32'(o_tx), 1);
      end else begin
         check("reset_test_start_seen", 0, 1);
      end
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("midreset_tx", 32'(o_tx), 1);
      check("midreset_busy", 32'(o_busy), 0);
      check("midreset_ready", 32'(o_ready), 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      f0 = start_cyc.size();
      repeat (3 * FRAME_CYC) @(negedge clk);
      check("no_frames_after_reset", start_cyc.size() - f0, 0);
      check("post_reset_busy", 32'(o_busy), 0);
      check("post_reset_tx", 32'(o_tx), 1);

      // random traffic with random gaps
      step();
      for (int i = 0; i < 20; i++) begin
         push_byte(DW'($urandom_range(0, 255)), 1, acc);
         repeat ($urandom_range(0, 3)) step();
      end
      k = 0;
      while (((exp_q.size() != 0) || mon_active) && (k < 22 * FRAME_CYC)) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("final_queue_empty", exp_q.size(), 0);
      check("final_monitor_idle", 32'(mon_active), 0);
      repeat (2) @(negedge clk);
      check("final_busy", 32'(o_busy), 0);

      // final report
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
